// File: rtl/hssl_pkt_cmd_decoder.sv
// Splits HSSL receive packets: command-key packets with payload become register
// write strobes, everything else is forwarded in order through a small FIFO.
module hssl_pkt_cmd_decoder #(
  parameter int unsigned ADR_BITS   = 8,
  parameter logic [31:0] CMD_KEY    = 32'hffff_fe00,
  parameter logic [31:0] CMD_MSK    = 32'hffff_ff00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [71:0]         pkt_data_in,
  input  logic                pkt_vld_in,
  output logic                pkt_rdy_out,
  output logic [71:0]         pkt_data_out,
  output logic                pkt_vld_out,
  input  logic                pkt_rdy_in,
  output logic [ADR_BITS-1:0] prx_addr_out,
  output logic [31:0]         prx_wdata_out,
  output logic                prx_en_out,
  output logic                cmd_cnt_out,
  output logic                err_cnt_out
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  logic [71:0]   s_data;
  logic          s_valid;
  logic [71:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          s_cmd;
  logic          s_wr;
  logic          s_err;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    s_cmd  = (s_data[39:8] & CMD_MSK) == (CMD_KEY & CMD_MSK);
    s_wr   = s_valid && s_cmd && s_data[1];
    s_err  = s_valid && s_cmd && !s_data[1];
    push   = s_valid && !s_cmd;
    pop    = (count != '0) && pkt_rdy_in;
    accept = pkt_vld_in && pkt_rdy_out;
  end

  // Counting the stage slot as occupied reserves FIFO room for whatever S holds,
  // so a forward packet in S can always be pushed without stalling.
  assign pkt_rdy_out  = (count + {{PW{1'b0}}, s_valid}) < DEPTH_C;
  assign pkt_vld_out  = (count != '0);
  assign pkt_data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid       <= 1'b0;
      s_data        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      prx_addr_out  <= '0;
      prx_wdata_out <= '0;
      prx_en_out    <= 1'b0;
      cmd_cnt_out   <= 1'b0;
      err_cnt_out   <= 1'b0;
    end else begin
      s_valid <= accept;
      if (accept) s_data <= pkt_data_in;

      prx_en_out  <= s_wr;
      cmd_cnt_out <= s_wr;
      err_cnt_out <= s_err;
      if (s_wr) begin
        prx_addr_out  <= s_data[ADR_BITS+7:8];
        prx_wdata_out <= s_data[71:40];
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/hssl_pkt_cmd_decoder.md
# hssl_pkt_cmd_decoder

Sits directly upstream of the register bank on the packet side: inspects every SpiNNaker packet arriving from the HSSL receive path, turns peripheral-command packets (key match plus payload) into single-cycle register write strobes on the bank's `prx_*` port, and forwards all other packets unchanged to the downstream packet path through a small FIFO. It also emits per-packet pulses for the diagnostic counters.

## Interface
- `ADR_BITS`, 8: register address width; must equal the bank's `REG_ADR_BITS`.
- `CMD_KEY`, 32'hffff_fe00: key value identifying command packets.
- `CMD_MSK`, 32'hffff_ff00: mask applied to the key before comparison.
- `FIFO_DEPTH`, 4: forward FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pkt_data_in`  in  72  packet: [7:0] header, [39:8] key, [71:40] payload; header bit 1 = payload present.
- `pkt_vld_in`  in  1  input packet valid.
- `pkt_rdy_out`  out  1  input ready.
- `pkt_data_out`  out  72  forwarded packet, bit-identical to input.
- `pkt_vld_out`  out  1  forwarded packet valid.
- `pkt_rdy_in`  in  1  downstream ready.
- `prx_addr_out`  out  ADR_BITS  register address (key[ADR_BITS-1:0]).
- `prx_wdata_out`  out  32  register write data (payload).
- `prx_en_out`  out  1  one-cycle write strobe.
- `cmd_cnt_out`  out  1  pulse: valid command written.
- `err_cnt_out`  out  1  pulse: command key without payload, dropped.

## Operation
- Transfer on an interface occurs at a rising edge where vld && rdy.
- Stage register S (data, valid) captures each accepted input packet.
- Classification of S: command = ((key & CMD_MSK) == (CMD_KEY & CMD_MSK)); has_pl = header[1].
- S valid, command, has_pl: register prx_addr_out <= key[ADR_BITS-1:0], prx_wdata_out <= payload, prx_en_out <= 1, cmd_cnt_out <= 1; S cleared unless refilled.
- S valid, command, no payload: nothing written; err_cnt_out <= 1; packet dropped.
- S valid, not command: packet pushed into forward FIFO; never dropped.
- prx_en_out, cmd_cnt_out, err_cnt_out are 0 in every cycle not covered above. Write strobes are never stalled: the bank gives packet writes priority.
- Flow control: pkt_rdy_out = (fifo_count + S_valid) < FIFO_DEPTH, derived only from registered state (no combinational path from pkt_rdy_in). This guarantees FIFO space for S whatever it contains.
- FIFO: pkt_vld_out = (fifo_count != 0); pkt_data_out = head entry; pop on pkt_vld_out && pkt_rdy_in; push and pop in the same cycle leave count unchanged; order preserved.
- Command and forward packets may interleave freely; relative order among forwarded packets is preserved.

## Timing
- Input accepted at edge E0; S valid after E0; command effect (prx_en_out / err_cnt_out high) registered at E1, visible for one cycle after E1.
- Forward packet pushed at E1; pkt_vld_out high after E1; minimum latency 2 cycles in both paths.
- Sustained throughput 1 packet/cycle with pkt_rdy_in held high and any mix of packets.
- Full: fifo_count + S_valid == FIFO_DEPTH → pkt_rdy_out low; it rises the cycle after a pop or after S drains a command.
- FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
- Reset (any time, including mid-packet): S_valid=0, fifo_count=0, pointers 0, pkt_rdy_out=1 once reset is deasserted (0 during reset is permitted but not required; spec value 1 as derived), pkt_vld_out=0, prx_en_out=0, prx_addr_out=0, prx_wdata_out=0, cmd_cnt_out=0, err_cnt_out=0. In-flight packets are discarded.

## Test plan
- Command write: key 32'hffff_fe23, header 8'h02, payload 32'hdead_beef → prx_en_out high for exactly 1 cycle, 2 cycles after acceptance, with addr 8'h23, data 32'hdead_beef; cmd_cnt_out pulse; nothing forwarded.
- Command without payload: key 32'hffff_fe05, header 8'h00 → err_cnt_out single pulse, no prx_en_out, no output packet.
- Back-pressure: pkt_rdy_in=0, send 6 non-command packets → exactly 4 accepted (3 in FIFO + 1 in S), then pkt_rdy_out=0; release → all 4 emerge in order, bit-exact.
- Interleave at full rate with pkt_rdy_in=1: fwd A, cmd X, fwd B, cmd Y → outputs A then B; writes X then Y on consecutive strobes; no stalls.
- Commands while FIFO full (pkt_rdy_in=0): first command queued in S still blocks until space; the write still appears 1 cycle after space frees S's slot; FIFO order intact.
- Reset asserted with FIFO holding 3 packets and S valid → all outputs reach reset values immediately (asynchronously); after release no stale packet or strobe appears.
